// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared constants, frame sizing helpers and state encoding for the pixel packer
package pixel_pkg;

  localparam int BYTES_PER_PIXEL = 3;
  localparam int FIFO_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    PAD
  } state_t;

  function automatic int frame_bytes(input int n_strings, input int n_leds);
    return n_strings * n_leds * BYTES_PER_PIXEL;
  endfunction

  // Odd byte totals round up: the last word carries a zero upper byte.
  function automatic int frame_words(input int n_strings, input int n_leds);
    return (frame_bytes(n_strings, n_leds) + 1) / 2;
  endfunction

endpackage

// File: rtl/pixel_frame_packer_if.sv
// rtl/pixel_frame_packer_if.sv - host byte stream into the packer (master = host, slave = packer)
interface pixel_frame_packer_if;
  import pixel_pkg::*;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_sof;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_sof, input s_ready);
  modport slave  (input s_data, input s_valid, input s_sof, output s_ready);

endinterface

// File: rtl/pixel_frame_packer_scaler.sv
// rtl/pixel_frame_packer_scaler.sv - two-stage registered byte scale (in*(scale+1))>>8 with valid/tag pipe
module byte_scaler
  import pixel_pkg::*;
#(
  parameter int TAG_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic [7:0]       scale,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  logic [15:0]      mult_a;
  logic [15:0]      mult_b;
  logic [15:0]      prod;
  logic             prod_valid;
  logic [TAG_W-1:0] prod_tag;

  // scale+1 makes 255 the identity and keeps the product inside 16 bits.
  assign mult_a = {8'h00, in_data};
  assign mult_b = {8'h00, scale} + 16'd1;
  assign busy   = prod_valid | out_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      prod_tag   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
    end else begin
      prod       <= mult_a * mult_b;
      prod_valid <= in_valid;
      prod_tag   <= in_tag;
      out_valid  <= prod_valid;
      out_data   <= prod[15:8];
      out_tag    <= prod_tag;
    end
  end

endmodule

// File: rtl/pixel_frame_packer.sv
// rtl/pixel_frame_packer.sv - host RGB bytes to scaled G,R,B 16-bit FIFO words, always whole frames
module pixel_frame_packer
  import pixel_pkg::*;
#(
  parameter int N_STRINGS         = 4,
  parameter int N_LEDS_PER_STRING = 150,
  parameter int FIFO_ADDR_WIDTH   = 12,
  parameter int SPACE_MARGIN      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 brightness,
  pixel_frame_packer_if.slave        s,
  input  logic [FIFO_ADDR_WIDTH:0]   fifo_full_count,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_wr_data,
  output logic                       fifo_wr_en,
  output logic                       frame_done,
  output logic                       frame_padded,
  output logic                       byte_dropped,
  output logic                       busy
);

  localparam int TOTAL_BYTES  = frame_bytes(N_STRINGS, N_LEDS_PER_STRING);
  localparam int TOTAL_WORDS  = frame_words(N_STRINGS, N_LEDS_PER_STRING);
  localparam int BCW          = $clog2(TOTAL_BYTES + 1);
  localparam int WCW          = $clog2(TOTAL_WORDS + 1);
  localparam int ACCEPT_LIMIT = 2 ** FIFO_ADDR_WIDTH - SPACE_MARGIN;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(TOTAL_BYTES - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(TOTAL_WORDS - 1);

  state_t         state;
  logic [BCW-1:0] byte_cnt;
  logic [7:0]     bright_lat;
  logic           space_ok;
  logic           accept;
  logic           pad_inject;
  logic           in_valid;
  logic [7:0]     in_data;

  assign s.s_ready  = space_ok && ((state == IDLE) ||
                                   (state == ACTIVE && !(s.s_valid && s.s_sof)));
  assign accept     = s.s_valid && s.s_ready;
  assign pad_inject = (state == PAD) && space_ok;
  assign in_valid   = pad_inject || (accept && (state == ACTIVE || s.s_sof));
  assign in_data    = pad_inject ? 8'h00 : s.s_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      bright_lat   <= '0;
      space_ok     <= 1'b0;
      byte_dropped <= 1'b0;
    end else begin
      space_ok     <= 32'(fifo_full_count) < ACCEPT_LIMIT;
      byte_dropped <= (state == IDLE) && accept && !s.s_sof;
      case (state)
        IDLE: if (accept && s.s_sof) begin
          bright_lat <= brightness;
          byte_cnt   <= BCW'(1);
          state      <= ACTIVE;
        end
        ACTIVE: if (s.s_valid && s.s_sof) begin
          state <= PAD;
        end else if (accept) begin
          byte_cnt <= byte_cnt + 1'b1;
          if (byte_cnt == LAST_BYTE) state <= IDLE;
        end
        PAD: if (space_ok) begin
          byte_cnt <= byte_cnt + 1'b1;
          if (byte_cnt == LAST_BYTE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Collect R,G then hand the whole pixel to an issue buffer so the next pixel can fill meanwhile.
  logic [1:0] pos;
  logic [7:0] hold_r, hold_g;
  logic [7:0] iss_g, iss_r, iss_b, iss_scale;
  logic [1:0] iss_cnt;
  logic       iss_pad;
  logic [7:0] sc_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      pos       <= '0;
      hold_r    <= '0;
      hold_g    <= '0;
      iss_g     <= '0;
      iss_r     <= '0;
      iss_b     <= '0;
      iss_scale <= '0;
      iss_cnt   <= '0;
      iss_pad   <= 1'b0;
    end else begin
      if (iss_cnt != 2'd0) iss_cnt <= iss_cnt - 2'd1;
      if (in_valid) begin
        if (pos == 2'd2) begin
          pos       <= '0;
          iss_g     <= hold_g;
          iss_r     <= hold_r;
          iss_b     <= in_data;
          iss_scale <= bright_lat;
          iss_pad   <= (state == PAD);
          iss_cnt   <= 2'd3;
        end else begin
          pos <= pos + 2'd1;
          if (pos == 2'd0) hold_r <= in_data;
          else             hold_g <= in_data;
        end
      end
    end
  end

  always_comb begin
    sc_in = iss_b;
    case (iss_cnt)
      2'd3:    sc_in = iss_g;
      2'd2:    sc_in = iss_r;
      default: sc_in = iss_b;
    endcase
  end

  logic       sc_valid;
  logic [7:0] sc_data;
  logic       sc_pad;
  logic       sc_busy;

  byte_scaler #(.TAG_W(1)) u_scaler (
    .clk      (clk),
    .reset    (reset),
    .in_valid (iss_cnt != 2'd0),
    .in_data  (sc_in),
    .scale    (iss_scale),
    .in_tag   (iss_pad),
    .out_valid(sc_valid),
    .out_data (sc_data),
    .out_tag  (sc_pad),
    .busy     (sc_busy)
  );

  logic           have_lo;
  logic [7:0]     lo_byte;
  logic [BCW-1:0] pk_cnt;
  logic [WCW-1:0] word_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      have_lo      <= 1'b0;
      lo_byte      <= '0;
      pk_cnt       <= '0;
      word_cnt     <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      frame_done   <= 1'b0;
      frame_padded <= 1'b0;
    end else begin
      fifo_wr_en   <= 1'b0;
      frame_done   <= 1'b0;
      frame_padded <= 1'b0;
      if (sc_valid) begin
        pk_cnt <= pk_cnt + 1'b1;
        if (have_lo || pk_cnt == LAST_BYTE) begin
          fifo_wr_en   <= 1'b1;
          fifo_wr_data <= have_lo ? {sc_data, lo_byte} : {8'h00, sc_data};
          have_lo      <= 1'b0;
          if (word_cnt == LAST_WORD) begin
            word_cnt     <= '0;
            pk_cnt       <= '0;
            frame_done   <= 1'b1;
            frame_padded <= sc_pad;
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end else begin
          lo_byte <= sc_data;
          have_lo <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != IDLE) || (pos != 2'd0) || (iss_cnt != 2'd0) || sc_busy || have_lo;

endmodule

// File: tb/tb_pixel_frame_packer.sv
// tb/tb_pixel_frame_packer.sv - directed bench for pixel_frame_packer (2x3 with 16-word FIFO, and 1x1)
module tb_pixel_frame_packer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pixel_frame_packer_if ifa ();
  pixel_frame_packer_if ifb ();

  logic [7:0]  brightness_a, brightness_b;
  logic [4:0]  full_a;
  logic [12:0] full_b;
  logic [15:0] wr_data_a, wr_data_b;
  logic wr_en_a, done_a, padded_a, drop_a, busy_a;
  logic wr_en_b, done_b, padded_b, drop_b, busy_b;

  pixel_frame_packer #(.N_STRINGS(2), .N_LEDS_PER_STRING(3), .FIFO_ADDR_WIDTH(4), .SPACE_MARGIN(4)) dut_a (
    .clk(clk), .reset(reset), .brightness(brightness_a), .s(ifa), .fifo_full_count(full_a),
    .fifo_wr_data(wr_data_a), .fifo_wr_en(wr_en_a), .frame_done(done_a), .frame_padded(padded_a),
    .byte_dropped(drop_a), .busy(busy_a));

  pixel_frame_packer #(.N_STRINGS(1), .N_LEDS_PER_STRING(1), .FIFO_ADDR_WIDTH(12), .SPACE_MARGIN(4)) dut_b (
    .clk(clk), .reset(reset), .brightness(brightness_b), .s(ifb), .fifo_full_count(full_b),
    .fifo_wr_data(wr_data_b), .fifo_wr_en(wr_en_b), .frame_done(done_b), .frame_padded(padded_b),
    .byte_dropped(drop_b), .busy(busy_b));

  int checks = 0;
  int errors = 0;
  logic [15:0] q_a[$], q_b[$];
  int done_pos_a[$], done_pos_b[$];
  bit pad_a[$];
  int drops_a = 0;
  int occ = 0, max_occ = 0;
  bit track = 0;
  bit acc_a, acc_b, rdy_a;
  logic [7:0]  pat [3] = '{8'h11, 8'h22, 8'h33};
  logic [15:0] wpat[3] = '{16'h1122, 16'h2233, 16'h3311};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    acc_a = ifa.s_valid && ifa.s_ready;
    acc_b = ifb.s_valid && ifb.s_ready;
    rdy_a = ifa.s_ready;
    @(posedge clk);
    #1;
    if (wr_en_a) begin
      q_a.push_back(wr_data_a);
      if (track) occ++;
      if (done_a) begin
        done_pos_a.push_back(q_a.size());
        pad_a.push_back(padded_a);
      end
    end
    if (drop_a) drops_a++;
    if (occ > max_occ) max_occ = occ;
    if (track) full_a = 5'(occ);
    if (wr_en_b) begin
      q_b.push_back(wr_data_b);
      if (done_b) done_pos_b.push_back(q_b.size());
    end
  endtask

  task automatic send(input bit b, input logic [7:0] d, input bit sof);
    int n = 0;
    if (b) begin ifb.s_data = d; ifb.s_sof = sof; ifb.s_valid = 1'b1; end
    else   begin ifa.s_data = d; ifa.s_sof = sof; ifa.s_valid = 1'b1; end
    do begin tick(); n++; end while (!(b ? acc_b : acc_a) && n < 100);
    check("send_accept", 32'(b ? acc_b : acc_a), 32'd1);
  endtask

  task automatic send_pattern_frame_a();
    for (int i = 0; i < 18; i++) send(1'b0, pat[i % 3], i == 0);
    ifa.s_valid = 1'b0;
  endtask

  task automatic wait_done_a(input int k);
    int n = 0;
    while (done_pos_a.size() < k && n < 300) begin tick(); n++; end
    check("done_timeout_a", 32'(done_pos_a.size() >= k), 32'd1);
  endtask

  initial begin
    int base, nb, k, refused, d0;
    bit saw_ready;
    reset = 1'b1;
    brightness_a = 8'd255; brightness_b = 8'd255;
    full_a = '0; full_b = '0;
    ifa.s_data = '0; ifa.s_valid = 1'b0; ifa.s_sof = 1'b0;
    ifb.s_data = '0; ifb.s_valid = 1'b0; ifb.s_sof = 1'b0;
    repeat (3) tick();
    check("rst_s_ready",   32'(ifa.s_ready), 32'd0);
    check("rst_wr_en",     32'(wr_en_a), 32'd0);
    check("rst_wr_data",   32'(wr_data_a), 32'd0);
    check("rst_busy",      32'(busy_a), 32'd0);
    check("rst_done",      32'(done_a), 32'd0);
    check("rst_padded",    32'(padded_a), 32'd0);
    check("rst_dropped",   32'(drop_a), 32'd0);
    check("rst_s_ready_b", 32'(ifb.s_ready), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // 1: identity brightness, repeating pixel
    send_pattern_frame_a();
    wait_done_a(1);
    check("t1_word_count", 32'(q_a.size()), 32'd9);
    for (int i = 0; i < 9; i++) check($sformatf("t1_word%0d", i), 32'(q_a[i]), 32'(wpat[i % 3]));
    check("t1_done_pos", 32'(done_pos_a[0]), 32'd9);
    check("t1_padded", 32'(pad_a[0]), 32'd0);
    repeat (5) tick();
    check("t1_busy_idle", 32'(busy_a), 32'd0);

    // 2: brightness 127 latched at SOF, later change ignored
    base = q_a.size();
    brightness_a = 8'd127;
    send(1'b0, 8'h80, 1'b1);
    brightness_a = 8'd0;
    for (int i = 1; i < 18; i++) send(1'b0, 8'h80, 1'b0);
    ifa.s_valid = 1'b0;
    wait_done_a(2);
    for (int i = 0; i < 9; i++) check($sformatf("t2_word%0d", i), 32'(q_a[base + i]), 32'h4040);
    check("t2_done_pos", 32'(done_pos_a[1]), 32'(base + 9));
    check("t2_padded", 32'(pad_a[1]), 32'd0);
    brightness_a = 8'd255;

    // 3: SOF after 5 bytes forces padding, then a full frame
    base = q_a.size();
    send(1'b0, 8'h01, 1'b1);
    send(1'b0, 8'h02, 1'b0);
    send(1'b0, 8'h03, 1'b0);
    send(1'b0, 8'h04, 1'b0);
    send(1'b0, 8'h05, 1'b0);
    ifa.s_data = 8'h11; ifa.s_sof = 1'b1;
    refused = 0;
    tick();
    while (!acc_a && refused < 100) begin refused++; tick(); end
    check("t3_sof_refused_cycles", 32'(refused), 32'd14);
    for (int i = 1; i < 18; i++) send(1'b0, pat[i % 3], 1'b0);
    ifa.s_valid = 1'b0;
    wait_done_a(4);
    check("t3_word0", 32'(q_a[base]), 32'h0102);
    check("t3_word1", 32'(q_a[base + 1]), 32'h0503);
    check("t3_word2", 32'(q_a[base + 2]), 32'h0004);
    for (int i = 3; i < 9; i++) check($sformatf("t3_pad_word%0d", i), 32'(q_a[base + i]), 32'h0000);
    check("t3_done_pos", 32'(done_pos_a[2]), 32'(base + 9));
    check("t3_padded", 32'(pad_a[2]), 32'd1);
    for (int i = 0; i < 9; i++) check($sformatf("t3b_word%0d", i), 32'(q_a[base + 9 + i]), 32'(wpat[i % 3]));
    check("t3b_done_pos", 32'(done_pos_a[3]), 32'(base + 18));
    check("t3b_padded", 32'(pad_a[3]), 32'd0);

    // 4: one-LED frame, odd byte count
    send(1'b1, 8'hAA, 1'b1);
    send(1'b1, 8'hBB, 1'b0);
    send(1'b1, 8'hCC, 1'b0);
    ifb.s_valid = 1'b0;
    k = 0;
    while (done_pos_b.size() < 1 && k < 100) begin tick(); k++; end
    check("t4_word_count", 32'(q_b.size()), 32'd2);
    check("t4_word0", 32'(q_b[0]), 32'hAABB);
    check("t4_word1", 32'(q_b[1]), 32'h00CC);
    check("t4_done_pos", 32'(done_pos_b.size() > 0 ? done_pos_b[0] : 0), 32'd2);

    // 5: FIFO space threshold and occupancy bound
    full_a = 5'd12;
    repeat (2) tick();
    ifa.s_data = pat[0]; ifa.s_sof = 1'b1; ifa.s_valid = 1'b1;
    repeat (2) tick();
    check("t5_ready_at_12", 32'(rdy_a), 32'd0);
    check("t5_no_accept_at_12", 32'(acc_a), 32'd0);
    base = q_a.size();
    occ = 11; max_occ = 11; full_a = 5'd11; track = 1'b1;
    k = 0; saw_ready = 1'b0;
    for (int t = 0; t < 60 && k < 18; t++) begin
      ifa.s_data = pat[k % 3]; ifa.s_sof = (k == 0);
      tick();
      if (rdy_a) saw_ready = 1'b1;
      if (acc_a) k++;
    end
    ifa.s_valid = 1'b0;
    check("t5_ready_at_11", 32'(saw_ready), 32'd1);
    check("t5_stall_on_space", 32'(k < 18), 32'd1);
    check("t5_occ_bound", 32'(max_occ <= 16), 32'd1);
    check("t5_occ_reached", 32'(occ >= 12), 32'd1);
    track = 1'b0; occ = 0; full_a = '0;
    repeat (2) tick();
    for (int i = k; i < 18; i++) send(1'b0, pat[i % 3], i == 0);
    ifa.s_valid = 1'b0;
    wait_done_a(5);
    check("t5_word0", 32'(q_a[base]), 32'h1122);
    check("t5_word8", 32'(q_a[base + 8]), 32'h3311);
    check("t5_done_pos", 32'(done_pos_a[4]), 32'(base + 9));

    // 6: stray bytes dropped, reset mid-frame, then a clean frame
    d0 = drops_a;
    nb = q_a.size();
    for (int i = 0; i < 4; i++) send(1'b0, 8'h5A, 1'b0);
    ifa.s_valid = 1'b0;
    repeat (5) tick();
    check("t6_drops", 32'(drops_a - d0), 32'd4);
    check("t6_drop_no_write", 32'(q_a.size()), 32'(nb));
    for (int i = 0; i < 7; i++) send(1'b0, pat[i % 3], i == 0);
    ifa.s_valid = 1'b0;
    reset = 1'b1;
    nb = q_a.size();
    tick();
    reset = 1'b0;
    repeat (20) tick();
    check("t6_no_write_after_reset", 32'(q_a.size()), 32'(nb));
    check("t6_busy_after_reset", 32'(busy_a), 32'd0);
    check("t6_no_done_after_reset", 32'(done_pos_a.size()), 32'd5);
    base = q_a.size();
    send_pattern_frame_a();
    wait_done_a(6);
    for (int i = 0; i < 9; i++) check($sformatf("t6_word%0d", i), 32'(q_a[base + i]), 32'(wpat[i % 3]));
    check("t6_done_pos", 32'(done_pos_a[5]), 32'(base + 9));
    check("t6_padded", 32'(pad_a[5]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
